// File: rtl/fnd_scan_decoder.sv
`default_nettype none
//----------------------------------------------------------------------------
// fnd_scan_decoder : rebuilds the 4-digit BCD/binary value shown on a
//                    multiplexed active-low FND from its com/data lines.
// Revision         : 1.0
//----------------------------------------------------------------------------
module fnd_scan_decoder #(
  parameter int unsigned SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  fnd_com,
  input  logic [7:0]  fnd_data,
  output logic [15:0] digits,
  output logic [13:0] value,
  output logic [3:0]  dp,
  output logic        frame_valid,
  output logic        seg_err,
  output logic        changed
);

  localparam logic [15:0] C_SETTLE_LAST = 16'(SETTLE_CYCLES - 1);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_SETTLE   = 2'd1,
    S_CAPTURED = 2'd2
  } state_t;

  state_t      r_state;
  logic [3:0]  r_com;
  logic [7:0]  r_data;
  logic [3:0]  r_prev_com;
  logic [7:0]  r_prev_data;
  logic [15:0] r_cnt;
  logic [3:0]  r_mask;
  logic [15:0] r_slots;
  logic [3:0]  r_slot_dp;

  logic        w_com_valid;
  logic        w_same;
  logic [15:0] w_cnt_next;
  logic        w_capture;
  logic [3:0]  w_capture_bit;
  logic [3:0]  w_dec;
  logic        w_full;
  logic        w_err;
  logic [13:0] w_sum;
  logic [13:0] w_new_value;

  function automatic logic [3:0] seg_decode(input logic [6:0] seg);
    logic [3:0] d;
    case (seg)
      7'h40:   d = 4'd0;
      7'h79:   d = 4'd1;
      7'h24:   d = 4'd2;
      7'h30:   d = 4'd3;
      7'h19:   d = 4'd4;
      7'h12:   d = 4'd5;
      7'h02:   d = 4'd6;
      7'h78:   d = 4'd7;
      7'h00:   d = 4'd8;
      7'h10:   d = 4'd9;
      default: d = 4'hF;
    endcase
    return d;
  endfunction

  always_comb begin
    case (r_com)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: w_com_valid = 1'b1;
      default:                            w_com_valid = 1'b0;
    endcase
  end

  assign w_same        = ({r_com, r_data} == {r_prev_com, r_prev_data});
  assign w_cnt_next    = w_same ? (r_cnt + 16'd1) : 16'd0;
  // A digit already captured is not recaptured until the lines move again.
  assign w_capture     = w_com_valid && ((r_state != S_CAPTURED) || !w_same)
                         && (w_cnt_next == C_SETTLE_LAST);
  assign w_capture_bit = w_capture ? ~r_com : 4'b0000;
  assign w_dec         = seg_decode(r_data[6:0]);

  assign w_full = (r_mask == 4'b1111);
  assign w_err  = (r_slots[3:0]   == 4'hF) || (r_slots[7:4]   == 4'hF) ||
                  (r_slots[11:8]  == 4'hF) || (r_slots[15:12] == 4'hF);
  assign w_sum  = 14'(r_slots[15:12]) * 14'd1000 +
                  14'(r_slots[11:8])  * 14'd100  +
                  14'(r_slots[7:4])   * 14'd10   +
                  14'(r_slots[3:0]);
  assign w_new_value = w_err ? 14'd0 : w_sum;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_com       <= 4'b1111;
      r_data      <= 8'hFF;
      r_prev_com  <= 4'b1111;
      r_prev_data <= 8'hFF;
    end else begin
      r_com       <= fnd_com;
      r_data      <= fnd_data;
      r_prev_com  <= r_com;
      r_prev_data <= r_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
    end else if (!w_com_valid) begin
      r_state <= S_IDLE;
      r_cnt   <= 16'd0;
    end else if (w_capture) begin
      r_state <= S_CAPTURED;
      r_cnt   <= w_cnt_next;
    end else if ((r_state == S_CAPTURED) && w_same) begin
      r_state <= S_CAPTURED;
    end else begin
      r_state <= S_SETTLE;
      r_cnt   <= w_cnt_next;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_mask    <= 4'b0000;
      r_slots   <= 16'h0000;
      r_slot_dp <= 4'b0000;
    end else begin
      // Publishing clears the mask; a capture on that same edge starts the next frame.
      r_mask <= (w_full ? 4'b0000 : r_mask) | w_capture_bit;
      for (int i = 0; i < 4; i++) begin
        if (w_capture_bit[i]) begin
          r_slots[4*i +: 4] <= w_dec;
          r_slot_dp[i]      <= ~r_data[7];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      digits      <= 16'h0000;
      value       <= 14'd0;
      dp          <= 4'b0000;
      seg_err     <= 1'b0;
      frame_valid <= 1'b0;
      changed     <= 1'b0;
    end else begin
      frame_valid <= w_full;
      changed     <= w_full && ((w_new_value != value) || (r_slots != digits));
      if (w_full) begin
        digits  <= r_slots;
        value   <= w_new_value;
        dp      <= r_slot_dp;
        seg_err <= w_err;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_decoder.sv
`default_nettype none
//----------------------------------------------------------------------------
// tb_fnd_scan_decoder : scoreboard bench driving directed FND scans.
// Revision            : 1.0
//----------------------------------------------------------------------------
module tb_fnd_scan_decoder;

  logic        clk;
  logic        rst;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_data;
  logic [15:0] digits;
  logic [13:0] value;
  logic [3:0]  dp;
  logic        frame_valid;
  logic        seg_err;
  logic        changed;

  fnd_scan_decoder #(.SETTLE_CYCLES(16)) dut (
    .clk         (clk),
    .rst         (rst),
    .fnd_com     (fnd_com),
    .fnd_data    (fnd_data),
    .digits      (digits),
    .value       (value),
    .dp          (dp),
    .frame_valid (frame_valid),
    .seg_err     (seg_err),
    .changed     (changed)
  );

  typedef struct {
    logic [15:0] digits;
    logic [13:0] value;
    logic [3:0]  dp;
    logic        err;
    logic        chg;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;
  int   pushed = 0;
  int   seen   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_frame(input logic [15:0] d, input logic [13:0] v,
                              input logic [3:0] p, input logic e, input logic c);
    exp_t x;
    x.digits = d; x.value = v; x.dp = p; x.err = e; x.chg = c;
    q.push_back(x);
    pushed++;
  endtask

  task automatic hold(input logic [3:0] com, input logic [7:0] data, input int n);
    fnd_com  = com;
    fnd_data = data;
    repeat (n) @(negedge clk);
  endtask

  task automatic scan(input logic [7:0] d0, input logic [7:0] d1,
                      input logic [7:0] d2, input logic [7:0] d3);
    hold(4'b1110, d0, 40);
    hold(4'b1101, d1, 40);
    hold(4'b1011, d2, 40);
    hold(4'b0111, d3, 40);
  endtask

  // Monitor: every published frame must match the oldest expectation.
  always @(negedge clk) begin
    if (rst && frame_valid) begin
      seen++;
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_frame: got digits %0h value %0d expected no frame", digits, value);
      end else begin
        exp_t x;
        x = q.pop_front();
        chk("frame_digits",  32'(digits),  32'(x.digits));
        chk("frame_value",   32'(value),   32'(x.value));
        chk("frame_dp",      32'(dp),      32'(x.dp));
        chk("frame_seg_err", 32'(seg_err), 32'(x.err));
        chk("frame_changed", 32'(changed), 32'(x.chg));
      end
    end
    if (rst && changed && !frame_valid) begin
      checks++;
      errors++;
      $display("FAIL changed_without_frame: got changed 1 expected 0");
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1);
  end

  initial begin
    rst      = 1'b0;
    fnd_com  = 4'b1111;
    fnd_data = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_digits",      32'(digits),      32'h0);
    chk("rst_value",       32'(value),       32'h0);
    chk("rst_dp",          32'(dp),          32'h0);
    chk("rst_frame_valid", 32'(frame_valid), 32'h0);
    chk("rst_seg_err",     32'(seg_err),     32'h0);
    chk("rst_changed",     32'(changed),     32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // Basic 1234 frame, then identical repeats, then 9999.
    expect_frame(16'h1234, 14'd1234, 4'b0000, 1'b0, 1'b1);
    scan(8'h99, 8'hB0, 8'hA4, 8'hF9);
    expect_frame(16'h1234, 14'd1234, 4'b0000, 1'b0, 1'b0);
    scan(8'h99, 8'hB0, 8'hA4, 8'hF9);
    expect_frame(16'h1234, 14'd1234, 4'b0000, 1'b0, 1'b0);
    scan(8'h99, 8'hB0, 8'hA4, 8'hF9);
    expect_frame(16'h9999, 14'd9999, 4'b0000, 1'b0, 1'b1);
    scan(8'h90, 8'h90, 8'h90, 8'h90);

    // 10-cycle "7" glitch on the ones digit must not replace the captured 4.
    expect_frame(16'h1234, 14'd1234, 4'b0000, 1'b0, 1'b1);
    hold(4'b1110, 8'h99, 40);
    hold(4'b1110, 8'hF8, 10);
    hold(4'b1110, 8'h99, 10);
    hold(4'b1101, 8'hB0, 40);
    hold(4'b1011, 8'hA4, 40);
    hold(4'b0111, 8'hF9, 40);

    // Blank tens digit is undecodable.
    expect_frame(16'h12F4, 14'd0, 4'b0000, 1'b1, 1'b1);
    scan(8'h99, 8'hFF, 8'hA4, 8'hF9);

    // Invalid digit selects never capture.
    hold(4'b1111, 8'h99, 100);
    hold(4'b1100, 8'h99, 100);

    // Decimal point on the ones digit.
    expect_frame(16'h1234, 14'd1234, 4'b0001, 1'b0, 1'b1);
    scan(8'h19, 8'hB0, 8'hA4, 8'hF9);

    // Three slots captured, then reset discards them.
    hold(4'b1101, 8'hB0, 40);
    hold(4'b1011, 8'hA4, 40);
    hold(4'b0111, 8'hF9, 40);
    fnd_com  = 4'b1111;
    fnd_data = 8'hFF;
    rst      = 1'b0;
    repeat (2) @(negedge clk);
    chk("midrst_digits",      32'(digits),      32'h0);
    chk("midrst_value",       32'(value),       32'h0);
    chk("midrst_dp",          32'(dp),          32'h0);
    chk("midrst_frame_valid", 32'(frame_valid), 32'h0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    expect_frame(16'h0005, 14'd5, 4'b0000, 1'b0, 1'b1);
    scan(8'h92, 8'hC0, 8'hC0, 8'hC0);
    hold(4'b1111, 8'hFF, 30);

    chk("pending_frames", 32'(q.size()), 32'd0);
    chk("frame_count",    32'(seen),     32'(pushed));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
